prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the instruction-memory port: fills instruction memory from a byte
//  stream (UART RX) while the fetch stage is held off. It assembles little-endian
//  32-bit words and issues one write per word at word addresses, matching fetch's pc[15:2].
//  It checks a trailing XOR checksum and reports done/err.
//  Sits between the UART receiver and the instruction memory write port.
// PARAMETERS
//  ADDR_W   14         word-address width; memory depth = 2**ADDR_W words
//  TIMEOUT  1_000_000  max clk cycles between bytes once a load has started
// PORTS
//  clk       in   1       system clock; all state changes on posedge
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       one-cycle pulse: begin a load (ignored while busy)
//  rx_valid  in   1       one-cycle strobe: rx_byte is valid
//  rx_byte   in   8       received byte
//  we        out  1       instruction memory write enable, one cycle per word
//  waddr     out  ADDR_W  word address of write
//  wdata     out  32      word to write
//  busy      out  1       load in progress (any state except IDLE)
//  cpu_hold  out  1       hold fetch/CPU in reset; equal to busy
//  done      out  1       sticky: last load completed with good checksum
//  err       out  1       sticky: last load failed (checksum, length, timeout)
// BEHAVIOUR
//  - Reset (async): state=IDLE; we, waddr, wdata, busy, cpu_hold, done, err all 0.
//    Counters, word index and checksum are cleared; a partial word is discarded.
//  - Frame format: LEN_LO, LEN_HI (N = word count, 16 bit), 4*N data bytes
//    (byte 0 goes to wdata[7:0]), then CHK = XOR of all 4*N data bytes.
//  - States: IDLE -> LEN_LO -> LEN_HI -> DATA -> CHK -> IDLE.
//  - IDLE: start=1 -> LEN_LO; clear done, err, checksum and word index.
//    rx_valid in IDLE is ignored, including when it arrives in the same cycle as start.
//  - LEN_LO/LEN_HI: capture N on rx_valid.
//    N==0 -> CHK (expected checksum 0x00).
//    N > 2**ADDR_W -> err=1, return to IDLE.
//    Otherwise -> DATA.
//  - DATA: each rx_valid shifts a byte into the word and updates the checksum.
//    On the 4th byte, we=1 on the next cycle, with waddr = word index and the
//    assembled wdata. The index increments after the write.
//    After word N-1 is written -> CHK.
//  - Back-to-back rx_valid (every cycle) must be accepted with no loss.
//  - we is a single-cycle pulse; waddr/wdata hold their last values otherwise.
//  - CHK: on rx_valid, match -> done=1, mismatch -> err=1; then IDLE.
//  - Timeout: in any non-IDLE state, TIMEOUT cycles without rx_valid -> err=1,
//    return to IDLE, and no further writes. Words already written stay in memory.
//  - start while busy: ignored.
//  - Index width is ADDR_W+1 so that N = 2**ADDR_W does not wrap before completion.
//  - Reset mid-load: immediate abort; we drops asynchronously; done=err=0.
// TESTING
//  T1 start, bytes 01 00 | 13 00 00 00 | 13 -> one we, waddr=0, wdata=0x00000013;
//     done=1, err=0, busy=0.
//  T2 N=3, words 0x11223344, 0xAABBCCDD, 0x00000001, good CHK, bytes sent every cycle
//     -> we at addr 0,1,2 with exact data; done=1.
//  T3 same as T2 with CHK xor 0x01 -> all 3 writes occur; err=1, done=0.
//  T4 N=2, stop after 5 data bytes; TIMEOUT=100 -> after 100 idle cycles err=1,
//     busy=0, only addr 0 written.
//  T5 assert rst after 2 of 4 bytes of word 1 -> all outputs 0 immediately;
//     a new start+frame loads correctly from addr 0.
//  T6 start pulses during DATA and rx_valid in IDLE -> no effect.
//     N=0x4001 with ADDR_W=14 -> err=1, no writes.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream in / instruction-memory write port out, plus load status.
// slave: the loader itself; master: whatever feeds bytes and watches status.
// Plain wires; no storage in the interface.
interface prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  start, rx_valid, rx_byte,
        output we, waddr, wdata, busy, cpu_hold, done, err
    );

    modport master (
        output start, rx_valid, rx_byte,
        input  we, waddr, wdata, busy, cpu_hold, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Loads instruction memory from a framed byte stream: LEN_LO LEN_HI, 4*N LE data bytes, XOR CHK.
// Latency: one write pulse on the cycle after the 4th byte of each word is accepted.
// No backpressure: every rx_valid strobe is consumed, back-to-back bytes included.
module prog_loader #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    localparam int          IDX_W = ADDR_W + 1;
    localparam int          TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        nbyte_q, nbyte_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [15:0]       len_full;
    logic              timeout_hit;

    // Next-state, byte assembly, checksum, idle-gap timer and status updates.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        nbyte_d  = nbyte_q;
        word_d   = word_q;
        chk_d    = chk_q;
        tmo_d    = tmo_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        err_d    = err_q;
        len_full = {bus.rx_byte, len_q[7:0]};

        // The gap timer restarts on every accepted byte and only runs mid-load.
        timeout_hit = (state_q != S_IDLE) && !bus.rx_valid &&
                      (tmo_q == TO_W'(TIMEOUT - 1));
        if (state_q == S_IDLE || bus.rx_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // A byte arriving with start belongs to no frame and is dropped.
                if (bus.start) begin
                    state_d = S_LEN_LO;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    chk_d   = '0;
                    idx_d   = '0;
                    nbyte_d = '0;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_d[7:0] = bus.rx_byte;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else if ({16'd0, len_full} > DEPTH) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    chk_d   = chk_q ^ bus.rx_byte;
                    nbyte_d = nbyte_q + 2'd1;
                    if (nbyte_q == 2'd3) begin
                        // word_q already holds bytes 2:1:0, so byte 0 lands in [7:0].
                        we_d    = 1'b1;
                        waddr_d = idx_q[ADDR_W-1:0];
                        wdata_d = {bus.rx_byte, word_q};
                        idx_d   = idx_q + 1'b1;
                        if ((32'(idx_q) + 32'd1) == {16'd0, len_q}) begin
                            state_d = S_CHK;
                        end
                    end else begin
                        word_d = {bus.rx_byte, word_q[23:8]};
                    end
                end
            end
            S_CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled stream abandons the load; words already written are left alone.
        if (timeout_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any load immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            nbyte_q <= '0;
            word_q  <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            nbyte_q <= nbyte_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.cpu_hold = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames plus randomized frames checked against a word-list model.
module tb_prog_loader;
    localparam int AW = 14;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(AW)) bus ();
    prog_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];

    // Write monitor: one entry per cycle with we high.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            obs_addr.push_back(bus.waddr);
            obs_data.push_back(bus.wdata);
        end
    end

    // Model frame: fn words, word i belongs at address i.
    logic [31:0] fw[0:15];
    int          fn;

    function automatic logic [7:0] frame_chk();
        logic [7:0] c = 8'h00;
        for (int i = 0; i < fn; i++)
            for (int j = 0; j < 4; j++)
                c = c ^ 8'((fw[i] >> (8 * j)) & 32'hFF);
        return c;
    endfunction

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_body(input int gap_max, input logic [7:0] chk_xor);
        logic [15:0] n;
        logic [31:0] w;
        n = 16'(fn);
        send_byte(n[7:0], int'($urandom_range(gap_max, 0)));
        send_byte(n[15:8], int'($urandom_range(gap_max, 0)));
        for (int i = 0; i < fn; i++) begin
            w = fw[i];
            for (int j = 0; j < 4; j++)
                send_byte(8'((w >> (8 * j)) & 32'hFF), int'($urandom_range(gap_max, 0)));
        end
        send_byte(frame_chk() ^ chk_xor, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if ({bus.we, bus.busy, bus.cpu_hold, bus.done, bus.err} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {bus.we, bus.busy, bus.cpu_hold, bus.done, bus.err}); else pass_cnt++;
        total_cnt++; if (bus.waddr !== '0) $display("FAIL reset_waddr got %h want 0", bus.waddr); else pass_cnt++;
        total_cnt++; if (bus.wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", bus.wdata); else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        clear_obs();
        fn = 1; fw[0] = 32'h0000_0013;
        pulse_start();
        send_body(0, 8'h00);
        total_cnt++; if (obs_addr.size() !== 1) $display("FAIL t1_count got %0d want 1", obs_addr.size()); else pass_cnt++;
        if (obs_addr.size() == 1) begin
            total_cnt++; if (obs_addr[0] !== '0) $display("FAIL t1_addr got %h want 0", obs_addr[0]); else pass_cnt++;
            total_cnt++; if (obs_data[0] !== 32'h13) $display("FAIL t1_data got %h want 00000013", obs_data[0]); else pass_cnt++;
        end
        total_cnt++; if ({bus.done, bus.err, bus.busy} !== 3'b100) $display("FAIL t1_status done/err/busy got %b want 100", {bus.done, bus.err, bus.busy}); else pass_cnt++;
    endtask

    task automatic test_back_to_back(input logic [7:0] chk_xor, input string tag);
        logic exp_done;
        clear_obs();
        fn = 3; fw[0] = 32'h1122_3344; fw[1] = 32'hAABB_CCDD; fw[2] = 32'h0000_0001;
        exp_done = (chk_xor == 8'h00);
        pulse_start();
        total_cnt++; if ({bus.busy, bus.cpu_hold} !== 2'b11) $display("FAIL %s_busy_hold got %b want 11", tag, {bus.busy, bus.cpu_hold}); else pass_cnt++;
        send_body(0, chk_xor);
        total_cnt++; if (obs_addr.size() !== 3) $display("FAIL %s_count got %0d want 3", tag, obs_addr.size()); else pass_cnt++;
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            total_cnt++; if (obs_addr[i] !== AW'(i) || obs_data[i] !== fw[i]) $display("FAIL %s_write%0d got %h:%h want %h:%h", tag, i, obs_addr[i], obs_data[i], AW'(i), fw[i]); else pass_cnt++;
        end
        total_cnt++; if ({bus.done, bus.err, bus.busy} !== {exp_done, ~exp_done, 1'b0}) $display("FAIL %s_status done/err/busy got %b want %b", tag, {bus.done, bus.err, bus.busy}, {exp_done, ~exp_done, 1'b0}); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cnt;
        clear_obs();
        fn = 2; fw[0] = 32'hDEAD_BEEF; fw[1] = 32'h0102_0304;
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        send_byte(8'h04, 0);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 4 * TO) begin
            @(negedge clk);
            cnt++;
        end
        total_cnt++; if (cnt !== TO) $display("FAIL t4_idle_cycles got %0d want %0d", cnt, TO); else pass_cnt++;
        repeat (10) @(negedge clk);
        total_cnt++; if ({bus.err, bus.done, bus.busy} !== 3'b100) $display("FAIL t4_status err/done/busy got %b want 100", {bus.err, bus.done, bus.busy}); else pass_cnt++;
        total_cnt++; if (obs_addr.size() !== 1) $display("FAIL t4_count got %0d want 1", obs_addr.size()); else pass_cnt++;
        if (obs_addr.size() == 1) begin
            total_cnt++; if (obs_addr[0] !== '0 || obs_data[0] !== 32'hDEAD_BEEF) $display("FAIL t4_write got %h:%h want 0:deadbeef", obs_addr[0], obs_data[0]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_load();
        clear_obs();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        total_cnt++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) $display("FAIL t5_preload done/busy got %b%b want 01", bus.done, bus.busy); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({bus.we, bus.busy, bus.cpu_hold, bus.done, bus.err, bus.waddr, bus.wdata} !== '0) $display("FAIL t5_async_clear got we%b busy%b hold%b done%b err%b addr%h data%h want all 0", bus.we, bus.busy, bus.cpu_hold, bus.done, bus.err, bus.waddr, bus.wdata); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_obs();
        fn = 2; fw[0] = $urandom; fw[1] = $urandom;
        pulse_start();
        send_body(1, 8'h00);
        total_cnt++; if (obs_addr.size() !== 2) $display("FAIL t5_reload_count got %0d want 2", obs_addr.size()); else pass_cnt++;
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            total_cnt++; if (obs_addr[i] !== AW'(i) || obs_data[i] !== fw[i]) $display("FAIL t5_reload_write%0d got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], AW'(i), fw[i]); else pass_cnt++;
        end
        total_cnt++; if (bus.done !== 1'b1) $display("FAIL t5_reload_done got %b want 1", bus.done); else pass_cnt++;
    endtask

    task automatic test_ignored_inputs();
        // Bytes while idle do nothing.
        clear_obs();
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h13, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h13, 1);
        total_cnt++; if (obs_addr.size() !== 0 || bus.busy !== 1'b0) $display("FAIL t6_idle_rx writes %0d busy %b want 0 0", obs_addr.size(), bus.busy); else pass_cnt++;
        // Byte coincident with start is dropped; start mid-DATA is ignored.
        fn = 2; fw[0] = 32'hCAFE_F00D; fw[1] = 32'h7654_3210;
        bus.start = 1'b1; bus.rx_valid = 1'b1; bus.rx_byte = 8'h05;
        @(negedge clk);
        bus.start = 1'b0; bus.rx_valid = 1'b0;
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h0D, 0); send_byte(8'hF0, 0);
        pulse_start();
        send_byte(8'hFE, 0); send_byte(8'hCA, 0);
        send_byte(8'h10, 0); send_byte(8'h32, 0); send_byte(8'h54, 0); send_byte(8'h76, 0);
        send_byte(frame_chk(), 2);
        total_cnt++; if (obs_addr.size() !== 2) $display("FAIL t6_count got %0d want 2", obs_addr.size()); else pass_cnt++;
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            total_cnt++; if (obs_addr[i] !== AW'(i) || obs_data[i] !== fw[i]) $display("FAIL t6_write%0d got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], AW'(i), fw[i]); else pass_cnt++;
        end
        total_cnt++; if ({bus.done, bus.err} !== 2'b10) $display("FAIL t6_status done/err got %b want 10", {bus.done, bus.err}); else pass_cnt++;
        // One word beyond memory depth is refused up front.
        clear_obs();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h40, 2);
        total_cnt++; if ({bus.err, bus.done, bus.busy} !== 3'b100 || obs_addr.size() !== 0) $display("FAIL t6_oversize err/done/busy %b writes %0d want 100 0", {bus.err, bus.done, bus.busy}, obs_addr.size()); else pass_cnt++;
        // Zero-length frame: only a zero checksum is good.
        fn = 0;
        pulse_start();
        send_body(0, 8'h00);
        total_cnt++; if ({bus.done, bus.err, bus.busy} !== 3'b100 || obs_addr.size() !== 0) $display("FAIL t6_zero_len done/err/busy %b writes %0d want 100 0", {bus.done, bus.err, bus.busy}, obs_addr.size()); else pass_cnt++;
        pulse_start();
        send_body(0, 8'h5A);
        total_cnt++; if ({bus.done, bus.err} !== 2'b01) $display("FAIL t6_zero_len_bad done/err got %b want 01", {bus.done, bus.err}); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] chk_xor;
        logic       exp_done;
        for (int it = 0; it < 20; it++) begin
            clear_obs();
            fn = int'($urandom_range(8, 1));
            for (int i = 0; i < fn; i++) fw[i] = $urandom;
            chk_xor  = ($urandom_range(3, 0) == 0) ? 8'(($urandom_range(254, 0)) + 1) : 8'h00;
            exp_done = (chk_xor == 8'h00);
            pulse_start();
            send_body(int'($urandom_range(3, 0)), chk_xor);
            total_cnt++; if (obs_addr.size() !== fn) $display("FAIL rnd%0d_count got %0d want %0d", it, obs_addr.size(), fn); else pass_cnt++;
            for (int i = 0; i < obs_addr.size() && i < fn; i++) begin
                total_cnt++; if (obs_addr[i] !== AW'(i) || obs_data[i] !== fw[i]) $display("FAIL rnd%0d_write%0d got %h:%h want %h:%h", it, i, obs_addr[i], obs_data[i], AW'(i), fw[i]); else pass_cnt++;
            end
            total_cnt++; if ({bus.done, bus.err, bus.busy, bus.cpu_hold} !== {exp_done, ~exp_done, 2'b00}) $display("FAIL rnd%0d_status done/err/busy/hold got %b want %b", it, {bus.done, bus.err, bus.busy, bus.cpu_hold}, {exp_done, ~exp_done, 2'b00}); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back(8'h00, "t2");
        test_back_to_back(8'h01, "t3");
        test_timeout();
        test_reset_mid_load();
        test_ignored_inputs();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
